// File: rtl/seven_seg_scan_decoder.sv
// Recovers a full 8-digit hex frame from a multiplexed 7-segment scan bus.
// Optional build macro SEG_DP_CAPTURE_EN captures decimal points into dp_flags.
module seven_seg_scan_decoder #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  segment_data,
  input  logic [7:0]  digit_select,
  output logic [31:0] value,
  output logic        value_valid,
  output logic [7:0]  digit_error,
  output logic        seq_error,
  output logic [7:0]  dp_flags
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  exp_q, exp_d;
  logic [7:0]  seg_in_q, seg_in_d, sel_in_q, sel_in_d;
  logic [7:0]  seg_prev_q, seg_prev_d, sel_prev_q, sel_prev_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fired_q, fired_d;
  logic [31:0] pend_val_q, pend_val_d, value_q, value_d;
  logic [7:0]  pend_err_q, pend_err_d, err_q, err_d;
  logic [7:0]  pend_dp_q, pend_dp_d, dp_q, dp_d;
  logic        valid_q, valid_d, seq_q, seq_d;

  logic        chg, accept, dp_bit;
  logic [4:0]  dec;
  logic [2:0]  idx;

  // Returns {error, nibble}; the dp bit never affects the digit value.
  function automatic logic [4:0] decode_seg(input logic [7:0] p);
    case (p & 8'hFE)
      8'hFC: decode_seg = 5'h00;
      8'h60: decode_seg = 5'h01;
      8'hDA: decode_seg = 5'h02;
      8'hF2: decode_seg = 5'h03;
      8'h66: decode_seg = 5'h04;
      8'hB6: decode_seg = 5'h05;
      8'hBE: decode_seg = 5'h06;
      8'hE0: decode_seg = 5'h07;
      8'hFE: decode_seg = 5'h08;
      8'hF6: decode_seg = 5'h09;
      8'hEE: decode_seg = 5'h0A;
      8'h3E: decode_seg = 5'h0B;
      8'h9C: decode_seg = 5'h0C;
      8'h7A: decode_seg = 5'h0D;
      8'h9E: decode_seg = 5'h0E;
      8'h8E: decode_seg = 5'h0F;
      default: decode_seg = 5'h10;
    endcase
  endfunction

  function automatic logic [2:0] sel_index(input logic [7:0] sel);
    sel_index = '0;
    for (int i = 0; i < 8; i++)
      if (sel[i]) sel_index = 3'(i);
  endfunction

  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    pend_val_d = pend_val_q;
    pend_err_d = pend_err_q;
    pend_dp_d  = pend_dp_q;
    value_d    = value_q;
    err_d      = err_q;
    dp_d       = dp_q;
    valid_d    = 1'b0;
    seq_d      = 1'b0;

    seg_in_d   = segment_data;
    sel_in_d   = digit_select;
    seg_prev_d = seg_in_q;
    sel_prev_d = sel_in_q;

    // The run length in cnt_q describes the sample now held in the *_prev_q stage.
    chg     = {seg_in_q, sel_in_q} != {seg_prev_q, sel_prev_q};
    cnt_d   = chg ? 4'd1 : ((cnt_q >= STABLE_C) ? STABLE_C : cnt_q + 4'd1);
    accept  = (cnt_q == STABLE_C) && !fired_q && (sel_prev_q != 8'h00);
    fired_d = chg ? 1'b0 : (fired_q | accept);

    dec = decode_seg(seg_prev_q);
    idx = sel_index(sel_prev_q);
`ifdef SEG_DP_CAPTURE_EN
    dp_bit = seg_prev_q[0];
`else
    dp_bit = 1'b0;
`endif

    if (accept) begin
      if (state_q == SCAN && $onehot(sel_prev_q) && idx == exp_q) begin
        pend_val_d[{idx, 2'b00} +: 4] = dec[3:0];
        pend_err_d[idx]               = dec[4];
        pend_dp_d[idx]                = dp_bit;
        if (idx == 3'd7) begin
          value_d = pend_val_d;
          err_d   = pend_err_d;
          dp_d    = pend_dp_d;
          valid_d = 1'b1;
          state_d = IDLE;
          exp_d   = 3'd0;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else begin
        seq_d = (state_q == SCAN);
        // Digit 0 always (re)starts a frame; anything else unexpected drops to IDLE.
        if (sel_prev_q == 8'h01) begin
          pend_val_d = {28'd0, dec[3:0]};
          pend_err_d = {7'd0, dec[4]};
          pend_dp_d  = {7'd0, dp_bit};
          state_d    = SCAN;
          exp_d      = 3'd1;
        end else if (state_q == SCAN) begin
          pend_val_d = '0;
          pend_err_d = '0;
          pend_dp_d  = '0;
          state_d    = IDLE;
          exp_d      = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      exp_q      <= '0;
      seg_in_q   <= '0;
      sel_in_q   <= '0;
      seg_prev_q <= '0;
      sel_prev_q <= '0;
      cnt_q      <= '0;
      fired_q    <= 1'b0;
      pend_val_q <= '0;
      pend_err_q <= '0;
      pend_dp_q  <= '0;
      value_q    <= '0;
      err_q      <= '0;
      dp_q       <= '0;
      valid_q    <= 1'b0;
      seq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q      <= exp_d;
      seg_in_q   <= seg_in_d;
      sel_in_q   <= sel_in_d;
      seg_prev_q <= seg_prev_d;
      sel_prev_q <= sel_prev_d;
      cnt_q      <= cnt_d;
      fired_q    <= fired_d;
      pend_val_q <= pend_val_d;
      pend_err_q <= pend_err_d;
      pend_dp_q  <= pend_dp_d;
      value_q    <= value_d;
      err_q      <= err_d;
      dp_q       <= dp_d;
      valid_q    <= valid_d;
      seq_q      <= seq_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign digit_error = err_q;
  assign seq_error   = seq_q;
  assign dp_flags    = dp_q;

endmodule

// File: doc/seven_seg_scan_decoder.md
SEVEN_SEG_SCAN_DECODER -- requirements
Module: seven_seg_scan_decoder

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 2, number of consecutive identical (segment_data, digit_select) samples required to accept a digit; legal range 1..15.
REQ-002 SHALL provide port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL provide port segment_data  input  8  scanned segment pattern; bit7=a, bit6=b, bit5=c, bit4=d, bit3=e, bit2=f, bit1=g, bit0=dp; 1 = segment lit.
REQ-005 SHALL provide port digit_select  input  8  scanned digit strobe; bit i selects digit i; expected one-hot or zero.
REQ-006 SHALL provide port value  output  32  last complete frame; digit i in value[4i+3:4i].
REQ-007 SHALL provide port value_valid  output  1  one-cycle pulse when value is updated.
REQ-008 SHALL provide port digit_error  output  8  per-digit undecodable-pattern flags for the frame in value.
REQ-009 SHALL provide port seq_error  output  1  one-cycle pulse when a frame is aborted.
REQ-010 SHALL provide port dp_flags  output  8  per-digit decimal-point bits for the frame in value (see Configuration).

Function
REQ-011 SHALL register segment_data and digit_select once before any other use (input stage, 1 cycle).
REQ-012 SHALL count consecutive cycles with registered sample equal to previous registered sample; counter resets to 1 on any change and saturates at STABLE_CYCLES.
REQ-013 SHALL accept a digit in the cycle the counter reaches STABLE_CYCLES with registered digit_select nonzero; at most one acceptance per dwell, i.e. no re-acceptance until the sample changes.
REQ-014 SHALL ignore samples with digit_select == 0 (blanking); no acceptance, no state change, no error.
REQ-015 SHALL decode segment_data[7:1] by exact match: 0xFC->0, 0x60->1, 0xDA->2, 0xF2->3, 0x66->4, 0xB6->5, 0xBE->6, 0xE0->7, 0xFE->8, 0xF6->9, 0xEE->A, 0x3E->b, 0x9C->C, 0x7A->d, 0x9E->E, 0x8E->F (values shown with bit0 = 0; bit0 ignored for decode).
REQ-016 SHALL, on no match, store nibble 0 for that digit and set its pending error bit.
REQ-017 SHALL implement FSM with states IDLE and SCAN plus a 3-bit expected-digit index.
REQ-018 IDLE: acceptance of digit 0 -> store into pending frame, expected=1, go SCAN; acceptance of any other digit -> stay IDLE, no error.
REQ-019 SCAN: acceptance of expected digit k<7 -> store, expected=k+1; acceptance of digit 7 when expected=7 -> publish, go IDLE.
REQ-020 SCAN: acceptance of non-expected digit, or non-one-hot digit_select -> pulse seq_error, discard pending frame, clear pending flags, go IDLE; if the offending select is exactly digit 0, restart frame from it (go SCAN, expected=1).
REQ-021 Publish SHALL copy pending nibbles to value, pending error bits to digit_error, pending dp bits to dp_flags, and assert value_valid, all visible on the clock edge following the digit-7 acceptance cycle.
REQ-022 Between publishes, value, digit_error, dp_flags SHALL hold; value_valid and seq_error SHALL be 0 except for their single pulse cycles.
REQ-023 Worst-case latency from digit 7 first appearing at the inputs to value_valid = 1 + STABLE_CYCLES + 1 cycles.

Reset
REQ-024 SHALL, while reset is low at a rising clk edge, set value=0, value_valid=0, digit_error=0, dp_flags=0, seq_error=0, FSM=IDLE, expected=0, stability counter=0, input registers=0, pending frame cleared.
REQ-025 Reset asserted mid-frame SHALL discard the pending frame without seq_error or value_valid.

Configuration
REQ-026 With macro SEG_DP_CAPTURE_EN defined, SHALL capture segment_data[0] of each accepted digit into pending dp bit i and publish per REQ-021.
REQ-027 Without SEG_DP_CAPTURE_EN, dp_flags SHALL exist and be constant 0; dp bit ignored entirely.

Verification
REQ-028 Clean scan, STABLE_CYCLES=2: digits 0..7 showing 0xFC,0x60,0xDA,0xF2,0x66,0xB6,0xBE,0xE0, 3 cycles each -> one value_valid pulse, value=0x76543210, digit_error=0.
REQ-029 Glitch filter: digit 3 shown 1 cycle as 0x00 then 3 cycles as 0xF2 -> only 0xF2 accepted; frame completes without error.
REQ-030 Out-of-order: digits 0,1,3 -> seq_error pulse on digit 3 acceptance, no value_valid, value unchanged; following clean 0..7 frame publishes.
REQ-031 Bad pattern: digit 5 shows 0x02 (only g) in otherwise clean frame -> value[23:20]=0, digit_error=0x20.
REQ-032 Reset mid-frame after digit 4 accepted -> all outputs 0, no pulses; next clean frame publishes normally.
REQ-033 With SEG_DP_CAPTURE_EN, digit 2 as 0xDB in clean frame -> dp_flags=0x04; without macro -> dp_flags=0x00, value identical.
